// File: rtl/sap_pkg.sv
// Shared SAP definitions: arbiter state encoding, owner codes and default
// memory geometry for the 16x8 program/data memory.
package sap_pkg;

   localparam int SAP_ADDR_W = 4;
   localparam int SAP_DATA_W = 8;

   localparam logic OWNER_CPU = 1'b0;
   localparam logic OWNER_LDR = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between the CPU and loader ports.
// MEM_ARB_RR_EN selects round-robin tie-break; otherwise the loader wins ties.
module mem_arb_pick
   import sap_pkg::*;
(
   input  logic cpu_req,
   input  logic ldr_req,
   input  logic owner,
   output logic grant_any,
   output logic grant
);

`ifndef MEM_ARB_RR_EN
   logic unused_owner;
   assign unused_owner = owner;
`endif

   always_comb begin
      grant_any = cpu_req | ldr_req;
      grant     = OWNER_CPU;
      if (cpu_req && ldr_req) begin
`ifdef MEM_ARB_RR_EN
         // The port that was not served last wins the tie.
         grant = ~owner;
`else
         grant = OWNER_LDR;
`endif
      end else if (ldr_req) begin
         grant = OWNER_LDR;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for the shared SAP memory port (IDLE/ACCESS/RESP).
// Tie-break policy is chosen in mem_arb_pick via MEM_ARB_RR_EN.
module mem_arbiter
   import sap_pkg::*;
#(
   parameter int ADDR_W = SAP_ADDR_W,
   parameter int DATA_W = SAP_DATA_W
) (
   input  logic              sysclk,
   input  logic              reset,
   input  logic              clken,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_adr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              ldr_req,
   input  logic              ldr_we,
   input  logic [ADDR_W-1:0] ldr_adr,
   input  logic [DATA_W-1:0] ldr_wdata,
   output logic              ldr_ack,
   output logic [DATA_W-1:0] ldr_rdata,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_adr,
   output logic [DATA_W-1:0] mem_data_in,
   input  logic [DATA_W-1:0] mem_value,
   output logic              busy,
   output logic              owner,
   output arb_state_t        state
);

   // Handshake: a requester holds req (with we/adr/wdata) until its ack; the
   // inputs are sampled only on the grant edge, and ack is high exactly while
   // the FSM sits in RESP for that requester, qualified by clken.

   logic              grant_any;
   logic              grant;
   logic [ADDR_W-1:0] adr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] cpu_rdata_q;
   logic [DATA_W-1:0] ldr_rdata_q;

   mem_arb_pick u_pick (
      .cpu_req   (cpu_req),
      .ldr_req   (ldr_req),
      .owner     (owner),
      .grant_any (grant_any),
      .grant     (grant)
   );

   always_ff @(posedge sysclk) begin
      if (reset) begin
         state       <= IDLE;
         owner       <= OWNER_LDR;
         busy        <= 1'b0;
         mem_write   <= 1'b0;
         adr_q       <= '0;
         wdata_q     <= '0;
         cpu_ack     <= 1'b0;
         ldr_ack     <= 1'b0;
         cpu_rdata_q <= '0;
         ldr_rdata_q <= '0;
      end else if (clken) begin
         unique case (state)
            IDLE: begin
               if (grant_any) begin
                  state <= ACCESS;
                  owner <= grant;
                  busy  <= 1'b1;
                  if (grant == OWNER_LDR) begin
                     adr_q     <= ldr_adr;
                     wdata_q   <= ldr_wdata;
                     mem_write <= ldr_we;
                  end else begin
                     adr_q     <= cpu_adr;
                     wdata_q   <= cpu_wdata;
                     mem_write <= cpu_we;
                  end
               end
            end
            ACCESS: begin
               state     <= RESP;
               mem_write <= 1'b0;
               if (owner == OWNER_CPU) cpu_ack <= 1'b1;
               else                    ldr_ack <= 1'b1;
            end
            RESP: begin
               state   <= IDLE;
               busy    <= 1'b0;
               cpu_ack <= 1'b0;
               ldr_ack <= 1'b0;
               if (owner == OWNER_CPU) cpu_rdata_q <= mem_value;
               else                    ldr_rdata_q <= mem_value;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign mem_adr     = adr_q;
   assign mem_data_in = wdata_q;

   // The memory's read data only arrives in RESP, so it is passed through
   // while ack is high and held in the capture register afterwards.
   assign cpu_rdata = cpu_ack ? mem_value : cpu_rdata_q;
   assign ldr_rdata = ldr_ack ? mem_value : ldr_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter with a registered 16x8 memory model and a scoreboard
// of expected acks/read data; honours MEM_ARB_RR_EN for tie predictions.
module tb_mem_arbiter;
   import sap_pkg::*;

   localparam int AW = 4;
   localparam int DW = 8;

   logic          sysclk = 1'b0;
   logic          reset = 1'b1;
   logic          clken = 1'b1;
   logic          cpu_req = 1'b0, cpu_we = 1'b0;
   logic [AW-1:0] cpu_adr = '0;
   logic [DW-1:0] cpu_wdata = '0;
   logic          cpu_ack;
   logic [DW-1:0] cpu_rdata;
   logic          ldr_req = 1'b0, ldr_we = 1'b0;
   logic [AW-1:0] ldr_adr = '0;
   logic [DW-1:0] ldr_wdata = '0;
   logic          ldr_ack;
   logic [DW-1:0] ldr_rdata;
   logic          mem_write;
   logic [AW-1:0] mem_adr;
   logic [DW-1:0] mem_data_in;
   logic [DW-1:0] mem_value;
   logic          busy, owner;
   arb_state_t    state;

   logic [DW-1:0] mem [16];
   logic [DW-1:0] ref_mem [16];
   bit            mem_loaded;
   bit            half_rate = 1'b0;
   int            checks = 0;
   int            errors = 0;
   logic [DW+1:0] exp_q[$];   // {is_read, port, data}
   logic          cpu_ack_d = 1'b0, ldr_ack_d = 1'b0;

   mem_arbiter dut (
      .sysclk(sysclk), .reset(reset), .clken(clken),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_adr(ldr_adr), .ldr_wdata(ldr_wdata),
      .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
      .mem_write(mem_write), .mem_adr(mem_adr), .mem_data_in(mem_data_in),
      .mem_value(mem_value), .busy(busy), .owner(owner), .state(state)
   );

   // ---------------- clock / clken / memory model ----------------
   always #5 sysclk = ~sysclk;

   always @(posedge sysclk) begin
      #1;
      clken = half_rate ? ~clken : 1'b1;
   end

   function automatic logic [7:0] init_val(input int i);
      if (i == 9) return 8'h0F;
      return 8'(i * 29 + 7) ^ 8'h5A;
   endfunction

   always @(posedge sysclk) begin
      if (!mem_loaded) begin
         for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
         mem_loaded <= 1'b1;
      end else if (mem_write) begin
         mem[mem_adr] <= mem_data_in;
      end
      mem_value <= mem[mem_adr];
   end

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic score(input logic port, input logic [DW-1:0] rdata, input logic other_ack);
      logic [DW+1:0] e;
      chk("ack_exclusive", 32'(other_ack), 0);
      chk("ack_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("ack_port", 32'(port), 32'(e[DW]));
         if (e[DW+1]) chk("rdata", 32'(rdata), 32'(e[DW-1:0]));
      end
   endtask

   always @(negedge sysclk) begin
      if (!reset) begin
         if (cpu_ack && !cpu_ack_d) score(OWNER_CPU, cpu_rdata, ldr_ack);
         if (ldr_ack && !ldr_ack_d) score(OWNER_LDR, ldr_rdata, cpu_ack);
      end
      cpu_ack_d <= cpu_ack;
      ldr_ack_d <= ldr_ack;
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge sysclk);
      #2;
   endtask

   task automatic do_reset();
      tick();
      reset   = 1'b1;
      cpu_req = 1'b0;
      ldr_req = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
   endtask

   task automatic run_txn(input logic port, input logic we, input logic [AW-1:0] adr,
                          input logic [DW-1:0] wd, input bit drop_early,
                          output int lat, output int busy_n, output int ack_n, output int mw_n);
      int   n;
      bit   seen_busy;
      logic ack, prev_mw, prev_ck;
      tick();
      exp_q.push_back({~we, port, (we ? wd : ref_mem[adr])});
      if (we) ref_mem[adr] = wd;
      if (port == OWNER_CPU) begin
         cpu_req = 1'b1; cpu_we = we; cpu_adr = adr; cpu_wdata = wd;
      end else begin
         ldr_req = 1'b1; ldr_we = we; ldr_adr = adr; ldr_wdata = wd;
      end
      lat = 0; busy_n = 0; ack_n = 0; mw_n = 0; n = 0; seen_busy = 1'b0;
      prev_mw = mem_write; prev_ck = clken;
      while (n < 60) begin
         @(negedge sysclk);
         n++;
         if (half_rate && !prev_ck) chk("mw_frozen", 32'(mem_write), 32'(prev_mw));
         prev_mw = mem_write;
         prev_ck = clken;
         if (busy) busy_n++;
         if (mem_write) begin
            mw_n++;
            chk("mw_adr", 32'(mem_adr), 32'(adr));
            chk("mw_data", 32'(mem_data_in), 32'(wd));
         end
         if (busy && !seen_busy) begin
            seen_busy = 1'b1;
            chk("access_adr", 32'(mem_adr), 32'(adr));
            if (drop_early) begin
               cpu_req = 1'b0;
               cpu_adr = 4'hF;
            end
         end
         ack = (port == OWNER_CPU) ? cpu_ack : ldr_ack;
         if (ack) begin
            if (ack_n == 0) begin
               lat = n;
               chk("owner", 32'(owner), 32'(port));
               chk("resp_adr", 32'(mem_adr), 32'(adr));
               chk("resp_no_write", 32'(mem_write), 0);
               if (port == OWNER_CPU) cpu_req = 1'b0;
               else                   ldr_req = 1'b0;
            end
            ack_n++;
         end else if (ack_n > 0) begin
            break;
         end
      end
      chk("ack_seen", 32'(ack_n > 0), 1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int lat, bn, an, mn, n, acks;
      logic prev_any;
      logic p, w;
      logic [AW-1:0] a;
      logic [DW-1:0] d;

      for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
      do_reset();

      chk("rst_owner", 32'(owner), 1);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_cpu_ack", 32'(cpu_ack), 0);
      chk("rst_ldr_ack", 32'(ldr_ack), 0);
      chk("rst_cpu_rdata", 32'(cpu_rdata), 0);
      chk("rst_ldr_rdata", 32'(ldr_rdata), 0);
      chk("rst_mem_write", 32'(mem_write), 0);
      chk("rst_mem_adr", 32'(mem_adr), 0);
      chk("rst_mem_data_in", 32'(mem_data_in), 0);

      // CPU read of 0x9, ack in the 3rd cycle
      run_txn(OWNER_CPU, 1'b0, 4'h9, 8'h00, 1'b0, lat, bn, an, mn);
      chk("rd9_latency", 32'(lat), 3);
      chk("rd9_ack_width", 32'(an), 1);
      chk("rd9_busy_cycles", 32'(bn), 2);
      chk("rd9_no_write", 32'(mn), 0);
      chk("rd9_cpu_rdata_held", 32'(cpu_rdata), 32'h0F);

      // Loader write then CPU read-back
      run_txn(OWNER_LDR, 1'b1, 4'h5, 8'hA5, 1'b0, lat, bn, an, mn);
      chk("wr5_write_cycles", 32'(mn), 1);
      chk("wr5_latency", 32'(lat), 3);
      run_txn(OWNER_CPU, 1'b0, 4'h5, 8'h00, 1'b0, lat, bn, an, mn);
      chk("rd5_latency", 32'(lat), 3);

      // CPU drops req and moves its address right after the grant
      run_txn(OWNER_CPU, 1'b0, 4'h3, 8'h00, 1'b1, lat, bn, an, mn);
      chk("drop_ack_width", 32'(an), 1);

      // Random mix
      for (int k = 0; k < 10; k++) begin
         p = 1'($urandom_range(0, 1));
         w = 1'($urandom_range(0, 1));
         a = 4'($urandom_range(0, 15));
         d = 8'($urandom_range(0, 255));
         run_txn(p, w, a, d, 1'b0, lat, bn, an, mn);
         chk("rand_latency", 32'(lat), 3);
         chk("rand_write_cycles", 32'(mn), 32'(w));
      end

      // Half-rate clken
      half_rate = 1'b1;
      repeat (4) tick();
      run_txn(OWNER_LDR, 1'b1, 4'hC, 8'h3C, 1'b0, lat, bn, an, mn);
      chk("half_wr_ack_width", 32'(an), 2);
      chk("half_wr_busy", 32'(bn), 4);
      chk("half_wr_write_cycles", 32'(mn), 2);
      run_txn(OWNER_CPU, 1'b0, 4'hC, 8'h00, 1'b0, lat, bn, an, mn);
      chk("half_rd_ack_width", 32'(an), 2);
      chk("half_rd_busy", 32'(bn), 4);
      half_rate = 1'b0;
      repeat (4) tick();

      // Reset during ACCESS of a CPU write
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 4'h7; cpu_wdata = 8'h77;
      n = 0;
      do begin
         @(negedge sysclk);
         n++;
      end while (!busy && n < 10);
      chk("abort_reached_access", 32'(mem_write), 1);
      reset = 1'b1;
      @(negedge sysclk);
      chk("abort_state", 32'(state), 32'(IDLE));
      chk("abort_mem_write", 32'(mem_write), 0);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_cpu_ack", 32'(cpu_ack), 0);
      chk("abort_owner", 32'(owner), 1);
      cpu_req = 1'b0;
      tick();
      reset = 1'b0;
      repeat (8) tick();
      chk("abort_no_pending", 32'(exp_q.size()), 0);

      // Both ports request continuously
      do_reset();
`ifdef MEM_ARB_RR_EN
      for (int k = 0; k < 2; k++) begin
         exp_q.push_back({1'b1, OWNER_CPU, ref_mem[1]});
         exp_q.push_back({1'b1, OWNER_LDR, ref_mem[2]});
      end
`else
      for (int k = 0; k < 4; k++) exp_q.push_back({1'b1, OWNER_LDR, ref_mem[2]});
`endif
      cpu_we = 1'b0; cpu_adr = 4'h1; cpu_req = 1'b1;
      ldr_we = 1'b0; ldr_adr = 4'h2; ldr_req = 1'b1;
      acks = 0; n = 0; prev_any = 1'b0;
      while (acks < 4 && n < 100) begin
         @(negedge sysclk);
         n++;
         if ((cpu_ack | ldr_ack) && !prev_any) acks++;
         prev_any = cpu_ack | ldr_ack;
      end
      cpu_req = 1'b0;
      ldr_req = 1'b0;
      chk("tie_grants", 32'(acks), 4);
      repeat (6) tick();
      chk("tie_queue_drained", 32'(exp_q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

endmodule
